spi_wb_bridge: RTL and testbench

SPI-slave to Wishbone-master bridge: the initiator end of the 8-bit Wishbone bus. It accepts framed commands from an external SPI host, mode 0 (CPOL=0, CPHA=0), and issues single read/write Wishbone cycles into the address decoder, which routes them to RGB LED, UART and other peripherals. It runs entirely in the system clock domain, oversampling SPI pins, and reports hung cycles with a timeout error pulse.

---
 rtl/spi_wb_bridge.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_wb_bridge.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_wb_bridge.sv
// SPI mode-0 slave to 8-bit Wishbone master bridge; all logic runs on clk with oversampled SPI pins.
// Frames are CMD, ADDR, (TURN for reads), then DATA bytes; each byte drives at most one bus cycle.
module spi_wb_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    input  logic       wb_ack_i,
    output logic       err_o
);

    typedef enum logic [2:0] {F_IDLE, F_CMD, F_ADDR, F_TURN, F_DATA} frame_t;
    typedef enum logic {B_IDLE, B_BUSY} bus_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic       sclk_p0, sclk_p1, sclk_p2;
    logic       cs_p0, cs_p1, cs_p2;
    logic       mosi_p0, mosi_p1;

    frame_t     frame_st;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic       cmd_we, cmd_inc;
    logic [7:0] addr_reg;
    logic [7:0] tx_sr;
    logic       tx_wait;

    bus_t       bus_st;
    logic [7:0] tmo_cnt;
    logic       bus_inc;
    logic [7:0] rd_data;

    logic       sclk_rise, sclk_fall, byte_done;
    logic [7:0] rx_byte, rd_result;
    logic       launch_req, launch_we;
    logic [7:0] launch_adr, launch_dat;
    logic       bus_busy, bus_tmo, bus_done, rd_done, wr_inc_done;
    logic       turn_late, tx_late, frame_err;

    // Synchronizer stages p0/p1, edge-detect history p2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
            cs_p2   <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= spi_sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= spi_cs_n;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
            mosi_p0 <= spi_mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    always_comb begin
        sclk_rise   = sclk_p1 & ~sclk_p2;
        sclk_fall   = ~sclk_p1 & sclk_p2;
        rx_byte     = {rx_sr, mosi_p1};
        byte_done   = ~cs_p1 & ~cs_p2 & sclk_rise & (frame_st != F_IDLE) & (bit_cnt == 3'd7);
        bus_busy    = (bus_st == B_BUSY);
        bus_tmo     = bus_busy & ~wb_ack_i & (tmo_cnt == TMO_LAST);
        bus_done    = bus_busy & (wb_ack_i | bus_tmo);
        rd_done     = bus_done & ~wb_we_o;
        wr_inc_done = bus_done & wb_we_o & bus_inc;
        rd_result   = wb_ack_i ? wb_dat_i : 8'hFF;

        launch_req = 1'b0;
        launch_we  = 1'b0;
        launch_adr = addr_reg;
        launch_dat = wb_dat_o;
        if (byte_done) begin
            case (frame_st)
                F_ADDR: if (!cmd_we) begin
                    launch_req = 1'b1;
                    launch_adr = rx_byte;
                end
                F_DATA: if (cmd_we) begin
                    launch_req = 1'b1;
                    launch_we  = 1'b1;
                    launch_dat = rx_byte;
                end else if (cmd_inc) begin
                    launch_req = 1'b1;
                    launch_adr = addr_reg + 8'd1;
                end
                default: ;
            endcase
        end

        // A prefetched byte that is still outstanding when its first bit is sampled goes out as 0xFF
        turn_late = byte_done & (frame_st == F_TURN) & bus_busy & ~wb_we_o;
        tx_late   = tx_wait & ~rd_done & sclk_rise & ~cs_p1 & (frame_st == F_DATA) & (bit_cnt == 3'd0);
        frame_err = (launch_req & bus_busy) | turn_late | tx_late;
    end

    // Frame FSM: byte assembly, command decode, TX shifting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_st    <= F_IDLE;
            bit_cnt     <= 3'd0;
            rx_sr       <= 7'd0;
            cmd_we      <= 1'b0;
            cmd_inc     <= 1'b0;
            addr_reg    <= 8'h00;
            tx_sr       <= 8'h00;
            tx_wait     <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
        end else begin
            spi_miso_oe <= ~cs_p1;
            spi_miso    <= (frame_st == F_DATA && !cs_p1) ? tx_sr[7] : 1'b0;
            if (wr_inc_done)
                addr_reg <= addr_reg + 8'd1;
            if (rd_done && tx_wait) begin
                tx_sr   <= rd_result;
                tx_wait <= 1'b0;
            end
            if (cs_p1) begin
                frame_st <= F_IDLE;
                bit_cnt  <= 3'd0;
                tx_wait  <= 1'b0;
            end else if (cs_p2) begin
                frame_st <= F_CMD;
                bit_cnt  <= 3'd0;
            end else if (frame_st != F_IDLE) begin
                if (sclk_rise) begin
                    rx_sr   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (tx_late) begin
                        tx_sr   <= 8'hFF;
                        tx_wait <= 1'b0;
                    end
                    if (byte_done) begin
                        case (frame_st)
                            F_CMD: begin
                                cmd_we   <= rx_byte[7];
                                cmd_inc  <= rx_byte[0];
                                frame_st <= F_ADDR;
                            end
                            F_ADDR: begin
                                addr_reg <= rx_byte;
                                frame_st <= rx_byte[7] ? F_DATA : F_DATA;
                                if (!cmd_we)
                                    frame_st <= F_TURN;
                            end
                            F_TURN: begin
                                tx_sr    <= turn_late ? 8'hFF : rd_data;
                                frame_st <= F_DATA;
                            end
                            F_DATA: if (!cmd_we) begin
                                if (cmd_inc) begin
                                    addr_reg <= addr_reg + 8'd1;
                                    tx_wait  <= 1'b1;
                                    tx_sr    <= 8'h00;
                                end else begin
                                    tx_sr <= rd_data;
                                end
                            end
                            default: ;
                        endcase
                    end
                end else if (sclk_fall && frame_st == F_DATA && bit_cnt != 3'd0) begin
                    // The falling edge right after a byte boundary keeps the freshly loaded MSB
                    tx_sr <= {tx_sr[6:0], 1'b0};
                end
            end
        end
    end

    // Bus FSM: one Wishbone cycle at a time with ack timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_st   <= B_IDLE;
            tmo_cnt  <= 8'd0;
            bus_inc  <= 1'b0;
            rd_data  <= 8'h00;
            wb_adr_o <= 8'h00;
            wb_dat_o <= 8'h00;
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            err_o <= bus_tmo | frame_err;
            case (bus_st)
                B_IDLE: if (launch_req) begin
                    wb_adr_o <= launch_adr;
                    wb_dat_o <= launch_dat;
                    wb_we_o  <= launch_we;
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    bus_inc  <= cmd_inc;
                    tmo_cnt  <= 8'd0;
                    bus_st   <= B_BUSY;
                end
                B_BUSY: if (bus_done) begin
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    bus_st   <= B_IDLE;
                    if (!wb_we_o)
                        rd_data <= rd_result;
                end else begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                end
                default: bus_st <= B_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_wb_bridge.sv
// Bench for spi_wb_bridge: SPI host driver, Wishbone slave model and a cycle scoreboard.
`timescale 1ns/1ps
module tb_spi_wb_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sclk, spi_cs_n, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic       wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, err_o;

    int tests = 0;
    int fails = 0;

    logic [16:0] exp_q[$];
    logic [7:0]  mem[256];
    logic [7:0]  tx_buf[8];
    logic [7:0]  rx_buf[8];
    logic        ack_en = 1'b1;
    int          ack_delay = 3;
    int          wcnt = 0;
    int          ncyc = 0;
    int          err_cnt = 0;
    int          cyc_len = 0;
    int          last_len = 0;
    logic        cyc_seen = 1'b0;
    logic        err_at_fall = 1'b0;

    always #5 clk = ~clk;

    spi_wb_bridge #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i), .err_o(err_o)
    );

    // Wishbone slave: ack in the ack_delay-th clock of the cycle
    always @(posedge clk) begin
        wb_ack_i <= 1'b0;
        if (wb_cyc_o && !wb_ack_i && ack_en) begin
            if (wcnt == ack_delay - 2) begin
                wb_ack_i <= 1'b1;
                wb_dat_i <= mem[wb_adr_o];
                wcnt     <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    // Scoreboard: each new cycle is checked against the oldest expected transaction
    always @(negedge clk) begin
        logic [16:0] e;
        if (wb_cyc_o) begin
            if (!cyc_seen) begin
                cyc_seen = 1'b1;
                cyc_len  = 0;
                ncyc++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_cycle: got we=%0b adr=%h dat=%h, required none", wb_we_o, wb_adr_o, wb_dat_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({wb_we_o, wb_adr_o} !== e[16:8] || (e[16] && wb_dat_o !== e[7:0])) begin
                        fails++;
                        $display("FAIL wb_cycle: got we=%0b adr=%h dat=%h, required we=%0b adr=%h dat=%h",
                                 wb_we_o, wb_adr_o, wb_dat_o, e[16], e[15:8], e[7:0]);
                    end
                end
                tests++;
                if (wb_stb_o !== 1'b1) begin
                    fails++;
                    $display("FAIL stb_eq_cyc: got stb=%0b, required 1", wb_stb_o);
                end
            end
            cyc_len++;
        end else if (cyc_seen) begin
            cyc_seen    = 1'b0;
            last_len    = cyc_len;
            err_at_fall = err_o;
        end
        if (err_o) err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = b[i];
            tick(8);
            spi_sclk = 1'b1;
            r[i] = spi_miso;
            tick(8);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input int n);
        logic [7:0] r;
        spi_cs_n = 1'b0;
        tick(8);
        for (int k = 0; k < n; k++) begin
            spi_byte(tx_buf[k], 8, r);
            rx_buf[k] = r;
        end
        tick(8);
        spi_cs_n = 1'b1;
        tick(40);
    endtask

    task automatic check_int(input string name, input int got, input int req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick(4);
        tests++;
        if ({spi_miso, spi_miso_oe, wb_we_o, wb_cyc_o, wb_stb_o, err_o} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, required 000000", {spi_miso, spi_miso_oe, wb_we_o, wb_cyc_o, wb_stb_o, err_o});
        end
        tests++;
        if ({wb_adr_o, wb_dat_o} !== 16'h0000) begin
            fails++;
            $display("FAIL reset_bus: got %h, required 0000", {wb_adr_o, wb_dat_o});
        end
        rst = 1'b1;
        tick(4);
    endtask

    task automatic test_write;
        int n0 = ncyc, e0 = err_cnt;
        exp_q.push_back({1'b1, 8'h05, 8'hA5});
        tx_buf[0] = 8'h80; tx_buf[1] = 8'h05; tx_buf[2] = 8'hA5;
        spi_frame(3);
        check_int("write_count", ncyc - n0, 1);
        check_int("write_cyc_len", last_len, 3);
        check_int("write_err", err_cnt - e0, 0);
    endtask

    task automatic test_burst_write;
        int n0 = ncyc, e0 = err_cnt;
        exp_q.push_back({1'b1, 8'h20, 8'h11});
        exp_q.push_back({1'b1, 8'h21, 8'h22});
        exp_q.push_back({1'b1, 8'h22, 8'h33});
        tx_buf[0] = 8'h81; tx_buf[1] = 8'h20; tx_buf[2] = 8'h11; tx_buf[3] = 8'h22; tx_buf[4] = 8'h33;
        spi_frame(5);
        check_int("burst_count", ncyc - n0, 3);
        n0 = ncyc;
        exp_q.push_back({1'b1, 8'hFF, 8'h01});
        exp_q.push_back({1'b1, 8'h00, 8'h02});
        tx_buf[0] = 8'h81; tx_buf[1] = 8'hFF; tx_buf[2] = 8'h01; tx_buf[3] = 8'h02;
        spi_frame(4);
        check_int("wrap_count", ncyc - n0, 2);
        check_int("burst_err", err_cnt - e0, 0);
    endtask

    task automatic test_read;
        int n0 = ncyc;
        mem[8'h0F] = 8'h3C; mem[8'h10] = 8'h4D; mem[8'h11] = 8'h5E;
        exp_q.push_back({1'b0, 8'h0F, 8'h00});
        exp_q.push_back({1'b0, 8'h10, 8'h00});
        exp_q.push_back({1'b0, 8'h11, 8'h00});
        tx_buf[0] = 8'h01; tx_buf[1] = 8'h0F; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00; tx_buf[4] = 8'h00;
        spi_frame(5);
        check_int("read_hdr_miso", {rx_buf[0], rx_buf[1], rx_buf[2]}, 0);
        check_int("read_inc_b3", rx_buf[3], 8'h3C);
        check_int("read_inc_b4", rx_buf[4], 8'h4D);
        check_int("read_inc_count", ncyc - n0, 3);
        n0 = ncyc;
        exp_q.push_back({1'b0, 8'h0F, 8'h00});
        tx_buf[0] = 8'h00;
        spi_frame(5);
        check_int("read_fix_b3", rx_buf[3], 8'h3C);
        check_int("read_fix_b4", rx_buf[4], 8'h3C);
        check_int("read_fix_count", ncyc - n0, 1);
    endtask

    task automatic test_timeout;
        int e0 = err_cnt;
        ack_en = 1'b0;
        exp_q.push_back({1'b0, 8'h33, 8'h00});
        tx_buf[0] = 8'h00; tx_buf[1] = 8'h33; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
        spi_frame(4);
        check_int("tmo_cyc_len", last_len, 15);
        check_int("tmo_err_pulses", err_cnt - e0, 1);
        check_int("tmo_err_at_fall", err_at_fall, 1);
        check_int("tmo_miso", rx_buf[3], 8'hFF);
        ack_en = 1'b1;
    endtask

    task automatic test_abort;
        int n0 = ncyc, e0 = err_cnt;
        logic [7:0] r;
        spi_cs_n = 1'b0;
        tick(8);
        spi_byte(8'h80, 8, r);
        spi_byte(8'h05, 4, r);
        tick(8);
        spi_cs_n = 1'b1;
        tick(40);
        check_int("abort_count", ncyc - n0, 0);
        exp_q.push_back({1'b1, 8'h44, 8'h99});
        tx_buf[0] = 8'h80; tx_buf[1] = 8'h44; tx_buf[2] = 8'h99;
        spi_frame(3);
        check_int("after_abort_count", ncyc - n0, 1);
        check_int("abort_err", err_cnt - e0, 0);
    endtask

    task automatic test_reset_mid;
        int n0;
        logic [7:0] r;
        ack_en = 1'b0;
        exp_q.push_back({1'b1, 8'h50, 8'h77});
        spi_cs_n = 1'b0;
        tick(8);
        spi_byte(8'h80, 8, r);
        spi_byte(8'h50, 8, r);
        spi_byte(8'h77, 8, r);
        check_int("mid_cyc_high", wb_cyc_o, 1);
        rst = 1'b0;
        spi_cs_n = 1'b1;
        #1;
        tests++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o} !== 19'h0) begin
            fails++;
            $display("FAIL async_reset: got %h, required 0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o});
        end
        tick(4);
        rst = 1'b1;
        ack_en = 1'b1;
        tick(8);
        n0 = ncyc;
        exp_q.push_back({1'b1, 8'h60, 8'h12});
        tx_buf[0] = 8'h80; tx_buf[1] = 8'h60; tx_buf[2] = 8'h12;
        spi_frame(3);
        check_int("post_reset_count", ncyc - n0, 1);
        check_int("post_reset_len", last_len, 3);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        test_reset();
        test_write();
        test_burst_write();
        test_read();
        test_timeout();
        test_abort();
        test_reset_mid();
        check_int("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
